id_ex_pipe_reg: RTL and testbench
=================================

# id_ex_pipe_reg

ID/EX pipeline register of the 5-stage MIPS core. It sits directly downstream of the control unit and ALU decoder, and upstream of the execute-stage ALU and forwarding muxes. It captures the decode-stage control word (including the 3-bit ALU control code), the register-file read data, the register specifiers and the sign-extended immediate. It supports hold (stall) and bubble insertion (flush) driven by the hazard unit.

## Interface
- DATA_WIDTH, 32, width of RD1/RD2/SignImm datapaths
- REG_ADDR_W, 5, width of register specifiers Rs/Rt/Rd
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- StallE  in  1  hold current contents (EX stage frozen)
- FlushE  in  1  load a bubble (NOP) on the next edge
- ValidD  in  1  decode stage holds a real instruction
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  in  1 each  decode control bits
- ALUControlD  in  3  ALU operation code (010 add, 110 sub, 000 and, 001 or, 111 slt)
- RD1D, RD2D, SignImmD  in  DATA_WIDTH each  operands / immediate
- RsD, RtD, RdD  in  REG_ADDR_W each  register specifiers
- ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1 each  registered copies
- ALUControlE  out  3  registered ALU code
- RD1E, RD2E, SignImmE  out  DATA_WIDTH each; RsE, RtE, RdE  out  REG_ADDR_W each
- BubbleCntE  out  16  bubble counter (present only with ID_EX_BUBBLE_CNT_EN)

## Operation
- One register slice; no combinational path from any D input to any E output.
- Per-edge update priority: reset > FlushE > StallE > load.
- Load (FlushE=0, StallE=0): every E output takes its D input.
- Stall (StallE=1, FlushE=0): all E outputs hold their values; ValidD is ignored.
- Flush (FlushE=1, StallE ignored): bubble loaded.
  - ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE and RegDstE go to 0.
  - ALUControlE goes to 3'b010 (add: harmless, no exception path).
  - RD1E, RD2E, SignImmE, RsE, RtE and RdE go to 0. RsE/RtE = 0 guarantees no false forwarding match, because register 0 is never forwarded.
- ALUControlD is passed through unchecked. Codes 011/100/101 are registered as-is; legality is the decoder's responsibility.
- A bubble (ValidE=0) must never cause an architectural write. RegWriteE=0 and MemWriteE=0 are mandatory in every bubble.

## Timing
- Latency: exactly 1 cycle from D inputs to E outputs.
- Reset (rst_n=0, asynchronous): all outputs go immediately to the bubble values above (ALUControlE=3'b010, all others 0, BubbleCntE=0). They remain there while rst_n=0.
- Reset deassertion: the first rising edge with rst_n=1 performs a normal priority-resolved update.
- Reset asserted mid-stall or mid-flush: reset wins immediately; the stall is not resumed after release.
- StallE and FlushE asserted in the same cycle: flush wins and a bubble is loaded.
- Consecutive StallE cycles: contents are held indefinitely with no decay.

## Configuration
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - BubbleCntE port exists.
  - The counter increments by 1 on each rising edge where FlushE=1, or where a load occurs with ValidD=0.
  - It saturates at 16'hFFFF, holds during stall, and is cleared only by reset.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- Reset: drive rst_n=0 mid-cycle with random D inputs -> all outputs 0 and ALUControlE=3'b010 without waiting for a clock edge.
- Load: RD1D=32'h0000_00A5, ALUControlD=3'b110, RegWriteD=1, RtD=5'd9, ValidD=1 -> identical values on the E outputs exactly one edge later.
- Stall: load ALUControlD=3'b111, then StallE=1 for 3 edges while ALUControlD=3'b000 -> ALUControlE stays 3'b111 throughout; 3'b000 appears one edge after StallE drops.
- Flush with simultaneous stall: StallE=1, FlushE=1, RegWriteD=1, MemWriteD=1 -> after the edge, RegWriteE=0, MemWriteE=0, ValidE=0, RsE=RtE=0, ALUControlE=3'b010.
- Bubble counter (macro defined): 5 flush edges, then 2 stall edges -> BubbleCntE=5. Preload the counter near 16'hFFFF and flush 3 times -> it stays at 16'hFFFF.
- Macro undefined: the same bench minus BubbleCntE -> all other outputs cycle-identical to the macro-defined run.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with stall/flush; optional bubble counter (ID_EX_BUBBLE_CNT_EN)
module id_ex_pipe_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  ValidD,
  input  logic                  RegWriteD,
  input  logic                  MemtoRegD,
  input  logic                  MemWriteD,
  input  logic                  ALUSrcD,
  input  logic                  RegDstD,
  input  logic [2:0]            ALUControlD,
  input  logic [DATA_WIDTH-1:0] RD1D,
  input  logic [DATA_WIDTH-1:0] RD2D,
  input  logic [DATA_WIDTH-1:0] SignImmD,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RdD,
  output logic                  ValidE,
  output logic                  RegWriteE,
  output logic                  MemtoRegE,
  output logic                  MemWriteE,
  output logic                  ALUSrcE,
  output logic                  RegDstE,
  output logic [2:0]            ALUControlE,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] SignImmE,
  output logic [REG_ADDR_W-1:0] RsE,
  output logic [REG_ADDR_W-1:0] RtE,
  output logic [REG_ADDR_W-1:0] RdE
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]           BubbleCntE
`endif
);

  localparam logic [2:0] ALU_ADD = 3'b010;

  logic                  valid_q, valid_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic                  mem_write_q, mem_write_d;
  logic                  alu_src_q, alu_src_d;
  logic                  reg_dst_q, reg_dst_d;
  logic [2:0]            alu_ctrl_q, alu_ctrl_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
  logic [DATA_WIDTH-1:0] sign_imm_q, sign_imm_d;
  logic [REG_ADDR_W-1:0] rs_q, rs_d;
  logic [REG_ADDR_W-1:0] rt_q, rt_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;

  // Bubble: all control deasserted, add opcode, zero specifiers so forwarding never matches.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    mem_write_d  = mem_write_q;
    alu_src_d    = alu_src_q;
    reg_dst_d    = reg_dst_q;
    alu_ctrl_d   = alu_ctrl_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    sign_imm_d   = sign_imm_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    if (FlushE) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_write_d  = 1'b0;
      alu_src_d    = 1'b0;
      reg_dst_d    = 1'b0;
      alu_ctrl_d   = ALU_ADD;
      rd1_d        = '0;
      rd2_d        = '0;
      sign_imm_d   = '0;
      rs_d         = '0;
      rt_d         = '0;
      rd_d         = '0;
    end else if (!StallE) begin
      valid_d      = ValidD;
      reg_write_d  = RegWriteD;
      mem_to_reg_d = MemtoRegD;
      mem_write_d  = MemWriteD;
      alu_src_d    = ALUSrcD;
      reg_dst_d    = RegDstD;
      alu_ctrl_d   = ALUControlD;
      rd1_d        = RD1D;
      rd2_d        = RD2D;
      sign_imm_d   = SignImmD;
      rs_d         = RsD;
      rt_d         = RtD;
      rd_d         = RdD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      alu_ctrl_q   <= ALU_ADD;
      rd1_q        <= '0;
      rd2_q        <= '0;
      sign_imm_q   <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      alu_src_q    <= alu_src_d;
      reg_dst_q    <= reg_dst_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      sign_imm_q   <= sign_imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
    end
  end

  assign ValidE      = valid_q;
  assign RegWriteE   = reg_write_q;
  assign MemtoRegE   = mem_to_reg_q;
  assign MemWriteE   = mem_write_q;
  assign ALUSrcE     = alu_src_q;
  assign RegDstE     = reg_dst_q;
  assign ALUControlE = alu_ctrl_q;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign SignImmE    = sign_imm_q;
  assign RsE         = rs_q;
  assign RtE         = rt_q;
  assign RdE         = rd_q;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // Counts flushes and invalid loads; saturates so it never wraps back to a small value.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if ((FlushE || (!StallE && !ValidD)) && (bubble_cnt_q != 16'hFFFF))
      bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bubble_cnt_q <= 16'd0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign BubbleCntE = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - table-driven scoreboard bench for id_ex_pipe_reg (ID_EX_BUBBLE_CNT_EN aware)
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid, rw, m2r, mw, als, rdst;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
  } out_t;

  typedef struct {
    logic        stall, flush, valid, rw, m2r, mw, als, rdst;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    out_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic StallE, FlushE, ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, SignImmD;
  logic [4:0]  RsD, RtD, RdD;
  logic ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, SignImmE;
  logic [4:0]  RsE, RtE, RdE;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] BubbleCntE;
`endif

  int n_cmp = 0;
  int n_err = 0;
  out_t sb[$];
  vec_t tbl[$];
  out_t model_q;
  out_t bub;
  int   exp_cnt;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .RsE(RsE), .RtE(RtE), .RdE(RdE)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .BubbleCntE(BubbleCntE)
`endif
  );

  function automatic out_t actual();
    out_t a;
    a = {ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
         RD1E, RD2E, SignImmE, RsE, RtE, RdE};
    return a;
  endfunction

  function automatic out_t next_exp(vec_t v, out_t cur);
    out_t o;
    if (v.flush) o = bub;
    else if (v.stall) o = cur;
    else o = {v.valid, v.rw, v.m2r, v.mw, v.als, v.rdst, v.alu, v.rd1, v.rd2, v.imm, v.rs, v.rt, v.rd};
    return o;
  endfunction

  function automatic vec_t mk(logic stall, logic flush, logic valid, logic rw, logic mw,
                              logic [2:0] alu, logic [31:0] rd1, logic [4:0] rt);
    vec_t v;
    v.stall = stall; v.flush = flush; v.valid = valid; v.rw = rw; v.mw = mw;
    v.m2r = 1'($urandom); v.als = 1'($urandom); v.rdst = 1'($urandom);
    v.alu = alu; v.rd1 = rd1; v.rt = rt;
    v.rd2 = $urandom; v.imm = $urandom; v.rs = 5'($urandom_range(1, 31)); v.rd = 5'($urandom);
    v.exp = '0;
    return v;
  endfunction

  task automatic add(vec_t v);
    v.exp   = next_exp(v, model_q);
    model_q = v.exp;
    tbl.push_back(v);
  endtask

  task automatic check_out(string name, out_t e);
    out_t a;
    a = actual();
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic check_cnt(string name);
`ifdef ID_EX_BUBBLE_CNT_EN
    n_cmp++;
    if (BubbleCntE !== 16'(exp_cnt)) begin
      n_err++;
      $display("FAIL %s: got BubbleCntE=%h expected %h", name, BubbleCntE, 16'(exp_cnt));
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  task automatic drive(vec_t v);
    StallE = v.stall; FlushE = v.flush; ValidD = v.valid; RegWriteD = v.rw;
    MemtoRegD = v.m2r; MemWriteD = v.mw; ALUSrcD = v.als; RegDstD = v.rdst;
    ALUControlD = v.alu; RD1D = v.rd1; RD2D = v.rd2; SignImmD = v.imm;
    RsD = v.rs; RtD = v.rt; RdD = v.rd;
  endtask

  task automatic apply(vec_t v, string name);
    @(negedge clk);
    drive(v);
    sb.push_back(v.exp);
    if ((v.flush || (!v.stall && !v.valid)) && exp_cnt < 16'hFFFF) exp_cnt++;
    @(posedge clk);
    #1;
    check_out(name, sb.pop_front());
    check_cnt({name, "_cnt"});
  endtask

  task automatic run_live(vec_t v, string name);
    v.exp   = next_exp(v, model_q);
    model_q = v.exp;
    apply(v, name);
  endtask

  task automatic async_reset(string name);
    @(negedge clk);
    #2;
    drive(mk(1'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b1, 3'($urandom), $urandom, 5'($urandom)));
    rst_n = 1'b0;
    #1;
    model_q = bub;
    exp_cnt = 0;
    check_out(name, bub);
    check_cnt({name, "_cnt"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bub = '0;
    bub.alu = 3'b010;
    model_q = bub;
    exp_cnt = 0;
    rst_n = 1'b1;
    drive(mk(0, 0, 1, 1, 1, 3'b111, 32'hDEAD_BEEF, 5'd7));

    add(mk(0, 0, 1, 1, 0, 3'b110, 32'h0000_00A5, 5'd9));
    add(mk(0, 0, 1, 1, 0, 3'b111, $urandom, 5'd3));
    for (int i = 0; i < 3; i++) add(mk(1, 0, i[0], 1, 0, 3'b000, $urandom, 5'd4));
    add(mk(0, 0, 1, 0, 1, 3'b000, $urandom, 5'd5));
    add(mk(1, 1, 1, 1, 1, 3'b001, $urandom, 5'd6));
    add(mk(0, 0, 1, 1, 0, 3'b011, $urandom, 5'd8));
    add(mk(0, 0, 1, 1, 0, 3'b100, $urandom, 5'd10));
    add(mk(0, 0, 0, 0, 0, 3'b101, $urandom, 5'd11));
    for (int i = 0; i < 16; i++)
      add(mk($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 1'($urandom),
             1'($urandom), 1'($urandom), 3'($urandom), $urandom, 5'($urandom)));

    async_reset("reset_init");
    model_q = bub;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    run_live(mk(0, 0, 1, 1, 1, 3'b111, 32'h1234_5678, 5'd12), "pre_stall_load");
    run_live(mk(1, 0, 1, 0, 0, 3'b000, $urandom, 5'd13), "stall_before_reset");
    async_reset("reset_mid_stall");
    run_live(mk(0, 0, 1, 1, 0, 3'b001, 32'hCAFE_0001, 5'd14), "load_after_reset");
    run_live(mk(0, 1, 1, 1, 1, 3'b110, $urandom, 5'd15), "flush_then");
    async_reset("reset_mid_flush");
    run_live(mk(0, 0, 1, 0, 1, 3'b000, 32'h0BAD_F00D, 5'd16), "load_after_flush_reset");

`ifdef ID_EX_BUBBLE_CNT_EN
    async_reset("reset_cnt");
    for (int i = 0; i < 5; i++) run_live(mk(0, 1, 1, 1, 1, 3'b000, $urandom, 5'd1), "cnt_flush");
    for (int i = 0; i < 2; i++) run_live(mk(1, 0, 0, 1, 1, 3'b000, $urandom, 5'd1), "cnt_stall");
    n_cmp++;
    if (BubbleCntE !== 16'd5) begin
      n_err++;
      $display("FAIL cnt_five: got %h expected %h", BubbleCntE, 16'd5);
    end
    @(negedge clk);
    FlushE = 1'b1;
    repeat (65535) @(posedge clk);
    exp_cnt = 16'hFFFF;
    #1;
    check_cnt("cnt_sat_reach");
    for (int i = 0; i < 3; i++) run_live(mk(0, 1, 1, 0, 0, 3'b000, $urandom, 5'd1), "cnt_sat_hold");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
